piece_scheduler: RTL and testbench

PIECE_SCHEDULER -- requirements
Module: piece_scheduler

---
 rtl/piece_scheduler_pkg.sv | 42 ++++
 rtl/piece_lfsr.sv | 40 ++++
 rtl/piece_scheduler.sv | 128 ++++++++++++
 tb/tb_piece_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/piece_scheduler_pkg.sv
// Shared tetris definitions: piece codes, scheduler FSM encoding and the
// 8-bit LFSR next-state function used by the random generators.
package piece_scheduler_pkg;

    localparam logic [4:0] PIECE_NONE = 5'd0;
    localparam logic [4:0] PIECE_I    = 5'd1;
    localparam logic [4:0] PIECE_J    = 5'd3;
    localparam logic [4:0] PIECE_L    = 5'd7;
    localparam logic [4:0] PIECE_O    = 5'd11;
    localparam logic [4:0] PIECE_S    = 5'd12;
    localparam logic [4:0] PIECE_T    = 5'd14;
    localparam logic [4:0] PIECE_Z    = 5'd18;

    localparam logic [7:0] LFSR_RESET = 8'h01;
    localparam logic [6:0] BAG_FULL   = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } sched_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6], s[5] ^ s[7], s[4] ^ s[7], s[3] ^ s[7], s[2], s[1], s[0], s[7]};
    endfunction

    function automatic logic [4:0] piece_code(input logic [2:0] idx);
        logic [4:0] code;
        case (idx)
            3'd0:    code = PIECE_I;
            3'd1:    code = PIECE_J;
            3'd2:    code = PIECE_L;
            3'd3:    code = PIECE_O;
            3'd4:    code = PIECE_S;
            3'd5:    code = PIECE_T;
            3'd6:    code = PIECE_Z;
            default: code = PIECE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// 8-bit Galois-style LFSR with seed load; a zero seed is replaced by 8'h01
// so the register can never lock up at all-zeros.
module piece_lfsr
    import piece_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    // Next-state selection: load wins over step, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 8'h00) ? LFSR_RESET : seed;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // LFSR register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LFSR_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/piece_scheduler.sv
// 7-bag piece scheduler: an LFSR proposes pieces, a used-mask rejects repeats
// within a bag, and accepted pieces enter a DEPTH-entry head/preview queue.
module piece_scheduler
    import piece_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seed,
    input  logic        start,
    input  logic        take,
    output logic [4:0]  piece,
    output logic [14:0] preview,
    output logic        valid,
    output logic [2:0]  count
);

    sched_state_t state_q, state_d;
    logic [6:0]   mask_q, mask_d;
    logic [2:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic [4:0]   queue_q [DEPTH];
    logic [4:0]   queue_d [DEPTH];

    logic [7:0]   lfsr_s;
    logic [2:0]   cand_idx_s;
    logic [6:0]   mask_set_s;
    logic [2:0]   wr_idx_s;
    logic         active_s;
    logic         take_acc_s;
    logic         push_s;

    piece_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .seed  (seed),
        .step  (active_s),
        .state (lfsr_s)
    );

    // Queue, bag mask and FSM next-state; start flushes, take shifts, push writes the tail.
    always_comb begin
        active_s   = (state_q != ST_IDLE);
        cand_idx_s = 3'(lfsr_s % 8'd7);
        take_acc_s = active_s && take && (count_q != 3'd0);
        push_s     = active_s && !mask_q[cand_idx_s] &&
                     ((count_q < 3'(DEPTH)) || take_acc_s);
        mask_set_s = mask_q | (7'd1 << cand_idx_s);
        wr_idx_s   = count_q;
        state_d    = state_q;
        mask_d     = mask_q;
        count_d    = count_q;
        queue_d    = queue_q;

        if (start) begin
            state_d = ST_FILL;
            mask_d  = 7'd0;
            count_d = 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_d[i] = PIECE_NONE;
            end
        end else if (active_s) begin
            if (take_acc_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    queue_d[i] = queue_q[i + 1];
                end
                queue_d[DEPTH - 1] = PIECE_NONE;
                wr_idx_s           = count_q - 3'd1;
                count_d            = count_q - 3'd1;
            end else begin
                wr_idx_s = count_q;
            end
            if (push_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (3'(i) == wr_idx_s) begin
                        queue_d[i] = piece_code(cand_idx_s);
                    end else begin
                        queue_d[i] = queue_d[i];
                    end
                end
                count_d = count_d + 3'd1;
                // Completing the bag starts a fresh one in the same cycle.
                mask_d  = (mask_set_s == BAG_FULL) ? 7'd0 : mask_set_s;
            end else begin
                mask_d = mask_q;
            end
            state_d = (count_d == 3'(DEPTH)) ? ST_FULL : ST_FILL;
        end else begin
            state_d = state_q;
        end

        valid_d = (count_d != 3'd0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= 7'd0;
            count_q <= 3'd0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= PIECE_NONE;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            valid_q <= valid_d;
            queue_q <= queue_d;
        end
    end

    assign piece = queue_q[0];
    assign valid = valid_q;
    assign count = count_q;

    for (genvar g = 1; g < 4; g++) begin : g_prev
        if (g < DEPTH) begin : g_on
            assign preview[5*g-1 -: 5] = queue_q[g];
        end else begin : g_off
            assign preview[5*g-1 -: 5] = PIECE_NONE;
        end
    end

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed bench for piece_scheduler with a behavioural queue/bag model as scoreboard.
module tb_piece_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  seed;
    logic        start;
    logic        take;
    logic [4:0]  piece;
    logic [14:0] preview;
    logic        valid;
    logic [2:0]  count;

    int n_asserts = 0;
    int n_fail    = 0;

    int codes [7] = '{1, 3, 7, 11, 12, 14, 18};

    logic [7:0] m_lfsr;
    logic [6:0] m_mask;
    bit         m_active;
    int         sb [$];
    int         issued [$];

    piece_scheduler #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .seed    (seed),
        .start   (start),
        .take    (take),
        .piece   (piece),
        .preview (preview),
        .valid   (valid),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_next(input logic [7:0] s);
        return {s[6], s[5] ^ s[7], s[4] ^ s[7], s[3] ^ s[7], s[2], s[1], s[0], s[7]};
    endfunction

    task automatic check_outputs(input string tag);
        int exp_p;
        exp_p = 0;
        for (int i = 1; i < 4; i++) begin
            if (i < sb.size()) exp_p = exp_p | (sb[i] << (5 * (i - 1)));
        end
        chk({tag, "_count"}, count, sb.size());
        chk({tag, "_piece"}, piece, (sb.size() > 0) ? sb[0] : 0);
        chk({tag, "_valid"}, valid, (sb.size() > 0) ? 1 : 0);
        chk({tag, "_preview"}, preview, exp_p);
    endtask

    task automatic cycle(input logic t, input logic s);
        int idx;
        bit acc;
        take  = t;
        start = s;
        if (s) begin
            m_lfsr   = (seed == 8'h00) ? 8'h01 : seed;
            m_mask   = 7'd0;
            sb.delete();
            m_active = 1'b1;
        end else if (m_active) begin
            idx = int'(m_lfsr % 8'd7);
            acc = t && (sb.size() > 0);
            if (acc) begin
                chk("take_head", piece, sb[0]);
                issued.push_back(sb.pop_front());
            end
            if (!m_mask[idx] && (sb.size() < DEPTH)) begin
                sb.push_back(codes[idx]);
                m_mask[idx] = 1'b1;
                if (m_mask == 7'h7F) m_mask = 7'd0;
            end
            m_lfsr = m_next(m_lfsr);
        end
        @(posedge clk);
        #1;
        take  = 1'b0;
        start = 1'b0;
        check_outputs("step");
    endtask

    task automatic do_reset(input logic t, input logic s);
        reset = 1'b0;
        take  = t;
        start = s;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        take     = 1'b0;
        start    = 1'b0;
        m_active = 1'b0;
        m_lfsr   = 8'h01;
        m_mask   = 7'd0;
        sb.delete();
        check_outputs("reset");
    endtask

    task automatic fill_to_full();
        for (int k = 0; k < 100 && count != 3'(DEPTH); k++) cycle(1'b0, 1'b0);
        chk("fill_full", count, DEPTH);
    endtask

    initial begin
        int bits;
        int idx;
        reset = 1'b0;
        seed  = 8'h00;
        start = 1'b0;
        take  = 1'b0;
        do_reset(1'b0, 1'b0);

        // Take with an empty queue after reset is ignored.
        cycle(1'b1, 1'b0);
        chk("empty_take_count", count, 0);
        chk("empty_take_piece", piece, 0);
        chk("empty_take_valid", valid, 0);

        // Seed 1: J, L, S on the first three edges.
        seed = 8'h01;
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        chk("seed1_piece", piece, 3);
        chk("seed1_prev1", preview[4:0], 7);
        chk("seed1_prev2", preview[9:5], 12);
        chk("seed1_count", count, 3);

        // Reset mid-fill, with start and take also high, discards the queue.
        seed = 8'h00;
        cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);
        chk("midfill_count", count, 2);
        do_reset(1'b1, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_piece", piece, 0);
        chk("rst_preview", preview, 0);
        repeat (2) cycle(1'b0, 1'b0);
        chk("idle_count", count, 0);

        // Seed 0 behaves like seed 1.
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        chk("seed0_piece", piece, 3);
        chk("seed0_prev1", preview[4:0], 7);
        chk("seed0_prev2", preview[9:5], 12);
        chk("seed0_count", count, 3);

        // Bag property over 14 issued pieces from a fresh start.
        seed = 8'hA5;
        cycle(1'b0, 1'b1);
        fill_to_full();
        issued.delete();
        for (int k = 0; k < 400 && issued.size() < 14; k++) cycle(1'b1, 1'b0);
        chk("bag_issued", (issued.size() >= 14) ? 1 : 0, 1);
        for (int g = 0; g < 2; g++) begin
            if (issued.size() >= 7 * g + 7) begin
                bits = 0;
                for (int k = 0; k < 7; k++) begin
                    idx = -1;
                    for (int c = 0; c < 7; c++) if (codes[c] == issued[7 * g + k]) idx = c;
                    if (idx >= 0) bits = bits | (1 << idx);
                end
                chk("bag_group", bits, 127);
            end
        end

        // Start together with take in FULL flushes and restarts from the seed.
        fill_to_full();
        seed = 8'h01;
        cycle(1'b1, 1'b1);
        chk("restart_count", count, 0);
        chk("restart_valid", valid, 0);
        repeat (3) cycle(1'b0, 1'b0);
        chk("restart_piece", piece, 3);
        chk("restart_prev1", preview[4:0], 7);
        chk("restart_prev2", preview[9:5], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
